// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared definitions for the byte-serial memory controller.
//   Bus widths, FSM state encodings, access-size codes, requester identity,
//   and the size-code to byte-count mapping.
package mem_ctrl_pkg;

   localparam int REG_BUS       = 32;  // CPU data path width
   localparam int INST_ADDR_BUS = 32;  // address width (fetch and load/store)
   localparam int RAM_DATA_BUS  = 8;   // byte-wide RAM data path

   typedef enum logic [1:0] {
      MCS_IDLE = 2'd0,
      MCS_RD   = 2'd1,
      MCS_WR   = 2'd2,
      MCS_DONE = 2'd3
   } mc_state_t;

   localparam logic [1:0] MEMSZ_B = 2'd0;
   localparam logic [1:0] MEMSZ_H = 2'd1;
   localparam logic [1:0] MEMSZ_W = 2'd2;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   // Size code 3 is not a legal RISC-V size; it is served as a full word.
   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      case (size)
         MEMSZ_B: return 3'd1;
         MEMSZ_H: return 3'd2;
         MEMSZ_W: return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl -- arbitrates instruction fetches and MEM-stage loads/stores onto
// a single byte-wide synchronous RAM, moving one byte per cycle.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   if_req_i / if_addr_i     fetch request (always 4 bytes) and address
//   if_data_o / if_done_o    fetched word, qualified by a one-cycle done pulse
//   mem_req_i, mem_we_i      load/store request, 1 = store
//   mem_size_i               0 byte, 1 half, 2/3 word
//   mem_addr_i, mem_wdata_i  byte address (unaligned allowed), store data
//   mem_rdata_o, mem_done_o  zero-extended load data, one-cycle done pulse
//   ram_addr_o, ram_we_o,    byte RAM address / write enable / write byte
//   ram_wdata_o
//   ram_rdata_i              RAM read byte, one cycle after its address
//   stall_if_o, stall_mem_o  pipeline stalls while a request is outstanding
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_req_i,
   input  logic [INST_ADDR_BUS-1:0] if_addr_i,
   output logic [REG_BUS-1:0]       if_data_o,
   output logic                     if_done_o,
   input  logic                     mem_req_i,
   input  logic                     mem_we_i,
   input  logic [1:0]               mem_size_i,
   input  logic [INST_ADDR_BUS-1:0] mem_addr_i,
   input  logic [REG_BUS-1:0]       mem_wdata_i,
   output logic [REG_BUS-1:0]       mem_rdata_o,
   output logic                     mem_done_o,
   output logic [INST_ADDR_BUS-1:0] ram_addr_o,
   output logic                     ram_we_o,
   output logic [RAM_DATA_BUS-1:0]  ram_wdata_o,
   input  logic [RAM_DATA_BUS-1:0]  ram_rdata_i,
   output logic                     stall_if_o,
   output logic                     stall_mem_o
);

   mc_state_t                state_q, state_d;
   owner_t                   owner_q;
   logic [INST_ADDR_BUS-1:0] base_q;
   logic [2:0]               nbytes_q;
   logic [2:0]               cnt_q;
   logic [REG_BUS-1:0]       wdata_q;
   logic [REG_BUS-1:0]       asm_q;

   // Current byte address; 32-bit addition wraps naturally past 0xFFFFFFFF.
   logic [INST_ADDR_BUS-1:0] byte_addr;
   logic [REG_BUS-1:0]       wdata_shift;

   assign byte_addr   = base_q + INST_ADDR_BUS'(cnt_q);
   assign wdata_shift = wdata_q >> {cnt_q, 3'b000};

   // Next state, RAM drive, done pulses and stalls.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would infer a latch.
      state_d     = state_q;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
      if_done_o   = 1'b0;
      mem_done_o  = 1'b0;

      case (state_q)
         MCS_IDLE: begin
            // MEM stage has priority; the fetch keeps waiting with a stall.
            if (mem_req_i)     state_d = mem_we_i ? MCS_WR : MCS_RD;
            else if (if_req_i) state_d = MCS_RD;
         end
         MCS_RD: begin
            // RD runs one extra cycle to catch the last byte's RAM latency;
            // no address is presented in that trailing cycle.
            if (cnt_q < nbytes_q) ram_addr_o = byte_addr;
            if (cnt_q == nbytes_q) state_d = MCS_DONE;
         end
         MCS_WR: begin
            ram_we_o    = 1'b1;
            ram_addr_o  = byte_addr;
            ram_wdata_o = wdata_shift[RAM_DATA_BUS-1:0];
            if (cnt_q == nbytes_q - 3'd1) state_d = MCS_DONE;
         end
         MCS_DONE: begin
            state_d    = MCS_IDLE;
            if_done_o  = (owner_q == OWN_IF);
            mem_done_o = (owner_q == OWN_MEM);
         end
         default: state_d = MCS_IDLE;
      endcase

      if_data_o   = if_done_o  ? asm_q : '0;
      mem_rdata_o = mem_done_o ? asm_q : '0;
      stall_if_o  = if_req_i  & ~if_done_o;
      stall_mem_o = mem_req_i & ~mem_done_o;
   end

   // NOTE: state and datapath registers use non-blocking assignments so all
   // of them update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: datapath registers are reset too, so a reset mid-transaction
         // leaves no stale owner, address or data behind.
         state_q  <= MCS_IDLE;
         owner_q  <= OWN_IF;
         base_q   <= '0;
         nbytes_q <= '0;
         cnt_q    <= '0;
         wdata_q  <= '0;
         asm_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            MCS_IDLE: begin
               if (mem_req_i || if_req_i) begin
                  cnt_q <= '0;
                  asm_q <= '0;  // clearing here gives zero-fill for short loads
                  if (mem_req_i) begin
                     owner_q  <= OWN_MEM;
                     base_q   <= mem_addr_i;
                     nbytes_q <= size_to_bytes(mem_size_i);
                     wdata_q  <= mem_we_i ? mem_wdata_i : '0;
                  end else begin
                     owner_q  <= OWN_IF;
                     base_q   <= if_addr_i;
                     nbytes_q <= 3'd4;
                     wdata_q  <= '0;
                  end
               end
            end
            MCS_RD: begin
               // The byte addressed in RD cycle k-1 is on ram_rdata_i now.
               for (int k = 0; k < 4; k++) begin
                  if (cnt_q == 3'(k + 1)) asm_q[8*k +: 8] <= ram_rdata_i;
               end
               cnt_q <= cnt_q + 3'd1;
            end
            MCS_WR:  cnt_q <= cnt_q + 3'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none; all widths come from Defines.vh (`RegBus = 32, `InstAddrBus = 32).
REQ-002 Single clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 if_req_i  in  1  instruction-fetch request, held until if_done_o.
REQ-006 if_addr_i  in  32  fetch address; always a 4-byte read.
REQ-007 if_data_o  out  32  fetched word; valid only while if_done_o=1.
REQ-008 if_done_o  out  1  one-cycle completion pulse for a fetch.
REQ-009 mem_req_i  in  1  load/store request from the MEM stage, held until mem_done_o.
REQ-010 mem_we_i  in  1  1 = store, 0 = load.
REQ-011 mem_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-012 mem_addr_i  in  32  byte address; alignment is not required.
REQ-013 mem_wdata_i  in  32  store data; the low size bytes are used.
REQ-014 mem_rdata_o  out  32  load data, zero-extended; valid only while mem_done_o=1.
REQ-015 mem_done_o  out  1  one-cycle completion pulse for a load or store.
REQ-016 ram_addr_o  out  32  byte-wide RAM address.
REQ-017 ram_we_o  out  1  RAM write enable.
REQ-018 ram_wdata_o  out  8  RAM write byte.
REQ-019 ram_rdata_i  in  8  RAM read byte; valid one cycle after its address is presented.
REQ-020 stall_if_o  out  1  asserted as if_req_i & ~if_done_o.
REQ-021 stall_mem_o  out  1  asserted as mem_req_i & ~mem_done_o.

Function
REQ-022 FSM states: IDLE, RD, WR, DONE.
- Requests are sampled only in IDLE.
- Flow: IDLE -> RD or WR on acceptance; RD/WR -> DONE on the last byte; DONE -> IDLE unconditionally.
REQ-023 Arbitration: if mem_req_i and if_req_i are both high in IDLE, MEM wins. IF waits with stall_if_o high.
REQ-024 On acceptance, the controller latches:
- owner (IF or MEM), base address, byte count N (1, 2 or 4), write data.
- A transaction runs to completion without preemption.
REQ-025 Byte order is little-endian: byte k uses address base+k and data bits [8k+7:8k].
REQ-026 Write operation:
- The state is WR for exactly N cycles.
- In cycle k of WR: ram_we_o=1, ram_addr_o=base+k, ram_wdata_o=byte k.
- DONE follows; mem_done_o is high in the DONE cycle.
REQ-027 Read operation:
- The state is RD for N+1 cycles.
- In RD cycle k (k<N): ram_addr_o=base+k, ram_we_o=0.
- ram_rdata_i is captured into byte k-1 at the end of RD cycle k, for 1<=k<=N.
- DONE follows; the owner's done and data outputs are valid in the DONE cycle.
REQ-028 Read latency: a word read completes 6 clock edges after the accepting edge.
REQ-029 Write latency: a word write completes 5 clock edges after the accepting edge.
REQ-030 A load of N<4 bytes zero-fills mem_rdata_o[31:8N].
REQ-031 Outside RD and WR, ram_we_o=0 and ram_addr_o=0.
- ram_wdata_o=0 whenever ram_we_o=0.
REQ-032 The address adds base+k modulo 2^32. 0xFFFFFFFF wraps to 0x00000000.
REQ-033 Only the owning requester's done output pulses; the other done output stays 0.
REQ-034 Back-to-back transactions have exactly one IDLE cycle between the DONE cycle and the next first RD/WR cycle.
REQ-035 A request dropped before done is a protocol violation; the transaction completes regardless.
REQ-036 if_data_o and mem_rdata_o are 0 whenever their done output is 0.

Reset
REQ-037 When rst=1 at a clock edge, the following take effect at that edge:
- state=IDLE.
- All latched registers and all outputs become 0.
REQ-038 Reset mid-transaction aborts the transaction: no done pulse is issued, and ram_we_o is 0 from the next cycle.
REQ-039 The first request can be accepted at the first edge with rst=0.

Structure
REQ-040 Defines.vh holds:
- the state encodings (MCS_IDLE, MCS_RD, MCS_WR, MCS_DONE);
- the size codes (MEMSZ_B, MEMSZ_H, MEMSZ_W);
- `RamDataBus [7:0].
REQ-041 The block is one module with no sub-module.
- Sequential logic: one FSM with a 3-bit byte counter and a 32-bit assembly register.
- Combinational logic: one block for the stall and RAM output decode.

Verification
REQ-042 Fetch timing: IF request at 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> if_data_o=0x00100513 with if_done_o high 6 edges after acceptance, and stall_if_o high until then.
REQ-043 Simultaneous requests: IF (0x0) and MEM load word (0x200) in the same IDLE cycle -> the MEM load is served first. The IF first address appears after DONE plus one IDLE cycle.
REQ-044 Store half: mem_wdata_i=0xA1B2C3D4 at 0x301 -> two WR cycles with (0x301,0xD4) and (0x302,0xC3), then mem_done_o for 1 cycle.
REQ-045 Load byte: 0xFF at 0x400 -> mem_rdata_o=0x000000FF, completing 3 edges after acceptance.
REQ-046 Reset mid-write: rst=1 in the second WR cycle of a word store -> ram_we_o=0 on the next cycle, no mem_done_o, and state IDLE.
REQ-047 Address wrap: word load at 0xFFFFFFFE -> RAM addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
